// File: rtl/ode_plotter.sv
// Projects decimated Lorenz solver states onto a 2-D screen plane, buffers visible
// points in a small FIFO and drains them to the framebuffer writer; also owns the clear sweep.
module ode_plotter #(
   parameter int WIDTH      = 27,
   parameter int FRAC       = 20,
   parameter int DECIM      = 4,
   parameter int SHIFT      = 17,
   parameter int H_OFF      = 320,
   parameter int V_OFF      = 240,
   parameter int SCREEN_W   = 640,
   parameter int SCREEN_H   = 480,
   parameter int FIFO_DEPTH = 8
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic signed [WIDTH-1:0] x_in,
   input  logic signed [WIDTH-1:0] y_in,
   input  logic signed [WIDTH-1:0] z_in,
   input  logic                    sample_valid,
   input  logic [1:0]              proj_sel,
   input  logic [7:0]              color,
   input  logic                    clear,
   output logic [9:0]              pix_x,
   output logic [9:0]              pix_y,
   output logic [7:0]              pix_color,
   output logic                    pix_valid,
   input  logic                    pix_ack,
   output logic                    busy,
   output logic [15:0]             dropped_count
);

   localparam int DEC_W = (DECIM > 1) ? $clog2(DECIM) : 1;
   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam logic [DEC_W-1:0] DEC_LAST  = DEC_W'(DECIM - 1);
   localparam logic [PTR_W:0]   CNT_FULL  = (PTR_W + 1)'(FIFO_DEPTH);
   localparam logic [9:0]       SW_LAST_X = 10'(SCREEN_W - 1);
   localparam logic [9:0]       SW_LAST_Y = 10'(SCREEN_H - 1);

   if (DECIM < 1 || SHIFT > FRAC || (1 << PTR_W) != FIFO_DEPTH) begin : g_param_check
      $error("ode_plotter: invalid DECIM, SHIFT/FRAC or FIFO_DEPTH");
   end

   typedef enum logic {ST_RUN, ST_CLEAR} state_t;

   state_t                  r_state;
   logic                    r_busy;
   logic                    r_clear_pend;
   logic [DEC_W-1:0]        r_dec_cnt;
   logic                    r_cap_valid;
   logic signed [WIDTH-1:0] r_cap_h;
   logic signed [WIDTH-1:0] r_cap_v;
   logic [7:0]              r_cap_color;
   logic                    r_prj_valid;
   logic [9:0]              r_prj_x;
   logic [9:0]              r_prj_y;
   logic [7:0]              r_prj_color;
   logic [27:0]             r_mem [FIFO_DEPTH];
   logic [PTR_W-1:0]        r_wr_ptr;
   logic [PTR_W-1:0]        r_rd_ptr;
   logic [PTR_W:0]          r_count;
   logic [9:0]              r_sw_x;
   logic [9:0]              r_sw_y;
   logic [15:0]             r_dropped;

   logic signed [WIDTH-1:0] w_h;
   logic signed [WIDTH-1:0] w_v;
   logic signed [WIDTH-1:0] w_hp;
   logic signed [WIDTH-1:0] w_vp;
   logic                    w_in_bounds;
   logic                    w_capture;
   logic                    w_empty;
   logic                    w_full;
   logic                    w_pop;
   logic                    w_push_ok;
   logic                    w_drop;
   logic [27:0]             w_head;

   always_comb begin
      w_h = x_in;
      w_v = z_in;
      case (proj_sel)
         2'd0:    begin w_h = x_in; w_v = y_in; end
         2'd2:    begin w_h = y_in; w_v = z_in; end
         default: begin w_h = x_in; w_v = z_in; end
      endcase
   end

   assign w_hp        = (r_cap_h >>> SHIFT) + WIDTH'(H_OFF);
   assign w_vp        = WIDTH'(V_OFF) - (r_cap_v >>> SHIFT);
   assign w_in_bounds = !w_hp[WIDTH-1] && (w_hp < WIDTH'(SCREEN_W)) &&
                        !w_vp[WIDTH-1] && (w_vp < WIDTH'(SCREEN_H));

   assign w_capture = sample_valid && (r_state == ST_RUN) && (r_dec_cnt == DEC_LAST);
   assign w_empty   = (r_count == '0);
   assign w_full    = (r_count == CNT_FULL);
   assign w_pop     = (r_state == ST_RUN) && !w_empty && pix_ack;
   // A full FIFO still accepts a push when the head leaves on the same edge.
   assign w_push_ok = r_prj_valid && (!w_full || w_pop);
   assign w_drop    = r_prj_valid && w_full && !w_pop;
   assign w_head    = r_mem[r_rd_ptr];

   always_comb begin
      pix_valid = 1'b0;
      pix_x     = '0;
      pix_y     = '0;
      pix_color = '0;
      if (r_state == ST_CLEAR) begin
         pix_valid = 1'b1;
         pix_x     = r_sw_x;
         pix_y     = r_sw_y;
      end else begin
         pix_valid = !w_empty;
         pix_x     = w_head[27:18];
         pix_y     = w_head[17:8];
         pix_color = w_head[7:0];
      end
   end

   assign busy          = r_busy;
   assign dropped_count = r_dropped;

   // NOTE: FIFO storage has no reset; validity comes from the pointers and count alone.
   always_ff @(posedge clk) begin
      if (w_push_ok) r_mem[r_wr_ptr] <= {r_prj_x, r_prj_y, r_prj_color};
   end

   // NOTE: every register here is updated with <= so all next-state terms see pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state      <= ST_RUN;
         r_busy       <= 1'b0;
         r_clear_pend <= 1'b0;
         r_dec_cnt    <= '0;
         r_cap_valid  <= 1'b0;
         r_cap_h      <= '0;
         r_cap_v      <= '0;
         r_cap_color  <= '0;
         r_prj_valid  <= 1'b0;
         r_prj_x      <= '0;
         r_prj_y      <= '0;
         r_prj_color  <= '0;
         r_wr_ptr     <= '0;
         r_rd_ptr     <= '0;
         r_count      <= '0;
         r_sw_x       <= '0;
         r_sw_y       <= '0;
         r_dropped    <= '0;
      end else begin
         if (sample_valid) r_dec_cnt <= (r_dec_cnt == DEC_LAST) ? '0 : r_dec_cnt + 1'b1;

         case (r_state)
            ST_RUN: begin
               if (clear) r_clear_pend <= 1'b1;

               r_cap_valid <= w_capture;
               if (w_capture) begin
                  r_cap_h     <= w_h;
                  r_cap_v     <= w_v;
                  r_cap_color <= color;
               end

               r_prj_valid <= r_cap_valid && w_in_bounds;
               r_prj_x     <= w_hp[9:0];
               r_prj_y     <= w_vp[9:0];
               r_prj_color <= r_cap_color;

               if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
               if (w_pop)     r_rd_ptr <= r_rd_ptr + 1'b1;
               r_count <= r_count + (PTR_W + 1)'(w_push_ok) - (PTR_W + 1)'(w_pop);

               if (w_drop && r_dropped != 16'hFFFF) r_dropped <= r_dropped + 1'b1;

               // Wait for any beat already on the port to finish before sweeping.
               if (r_clear_pend && (w_empty || pix_ack)) begin
                  r_state     <= ST_CLEAR;
                  r_busy      <= 1'b1;
                  r_cap_valid <= 1'b0;
                  r_prj_valid <= 1'b0;
                  r_wr_ptr    <= '0;
                  r_rd_ptr    <= '0;
                  r_count     <= '0;
                  r_sw_x      <= '0;
                  r_sw_y      <= '0;
               end
            end

            ST_CLEAR: begin
               if (pix_ack) begin
                  if (r_sw_x == SW_LAST_X) begin
                     r_sw_x <= '0;
                     if (r_sw_y == SW_LAST_Y) begin
                        r_sw_y       <= '0;
                        r_state      <= ST_RUN;
                        r_busy       <= 1'b0;
                        r_clear_pend <= 1'b0;
                     end else begin
                        r_sw_y <= r_sw_y + 1'b1;
                     end
                  end else begin
                     r_sw_x <= r_sw_x + 1'b1;
                  end
               end
            end

            default: r_state <= ST_RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_ode_plotter.sv
// Directed bench for ode_plotter: dut_a uses the default screen with DECIM=1,
// dut_b a 16x8 screen with DECIM=4 so a full clear sweep stays short.
module tb_ode_plotter;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic signed [26:0] x_in, y_in, z_in;
   logic              sample_valid, clear, ack_a, ack_b;
   logic [1:0]        proj_sel;
   logic [7:0]        color;

   logic [9:0]  a_x, a_y, b_x, b_y;
   logic [7:0]  a_color, b_color;
   logic        a_valid, b_valid, a_busy, b_busy;
   logic [15:0] a_drop, b_drop;

   int n_total = 0;
   int n_bad   = 0;

   ode_plotter #(.DECIM(1)) dut_a (
      .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .sample_valid(sample_valid), .proj_sel(proj_sel), .color(color), .clear(clear),
      .pix_x(a_x), .pix_y(a_y), .pix_color(a_color), .pix_valid(a_valid),
      .pix_ack(ack_a), .busy(a_busy), .dropped_count(a_drop)
   );

   ode_plotter #(.DECIM(4), .H_OFF(8), .V_OFF(4), .SCREEN_W(16), .SCREEN_H(8)) dut_b (
      .clk(clk), .reset(reset), .x_in(x_in), .y_in(y_in), .z_in(z_in),
      .sample_valid(sample_valid), .proj_sel(proj_sel), .color(color), .clear(clear),
      .pix_x(b_x), .pix_y(b_y), .pix_color(b_color), .pix_valid(b_valid),
      .pix_ack(ack_b), .busy(b_busy), .dropped_count(b_drop)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      sample_valid = 1'b0;
      clear        = 1'b0;
      reset        = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
   endtask

   initial begin
      int beats;
      int n;
      int errs;
      int bx[2];
      int by[2];
      int bc;

      x_in = '0; y_in = '0; z_in = '0;
      sample_valid = 1'b0; clear = 1'b0; ack_a = 1'b0; ack_b = 1'b0;
      proj_sel = 2'd0; color = 8'h00;
      do_reset();

      check("rst_a_valid", a_valid, 0);
      check("rst_a_drop", a_drop, 0);
      check("rst_b_valid", b_valid, 0);
      check("rst_b_busy", b_busy, 0);

      // Mapping and latency: +1.0 / -1.0 land 8 px right and 8 px down of centre.
      color = 8'hA5; x_in = 27'sd1048576; y_in = -27'sd1048576; sample_valid = 1'b1;
      step(); sample_valid = 1'b0;
      check("map_c1_valid", a_valid, 0);
      step();
      check("map_c2_valid", a_valid, 0);
      step();
      check("map_c3_valid", a_valid, 1);
      check("map_x", a_x, 328);
      check("map_y", a_y, 248);
      check("map_color", a_color, 8'hA5);
      ack_a = 1'b1; step(); ack_a = 1'b0;
      check("map_popped", a_valid, 0);

      // Decimation: 8 samples at DECIM=4, only the 4th (hp=8) and 8th (hp=12) survive.
      do_reset(); ack_b = 1'b1; y_in = '0; color = 8'h3C; beats = 0; bc = 0;
      for (int i = 1; i <= 14; i++) begin
         sample_valid = (i <= 8);
         x_in = 27'((i - 4) * 131072);
         if (b_valid && ack_b) begin
            if (beats < 2) begin bx[beats] = b_x; by[beats] = b_y; end
            bc = b_color;
            beats++;
         end
         step();
      end
      sample_valid = 1'b0;
      check("dec_beats", beats, 2);
      check("dec_first_x", bx[0], 8);
      check("dec_second_x", bx[1], 12);
      check("dec_y", by[0], 4);
      check("dec_color", bc, 8'h3C);

      // Clipping: hp=720 is discarded silently, hp=0 is drawn.
      do_reset(); ack_a = 1'b1; y_in = '0; x_in = 27'sd52428800; sample_valid = 1'b1;
      step(); sample_valid = 1'b0; beats = 0;
      repeat (6) begin if (a_valid) beats++; step(); end
      check("clip_beats", beats, 0);
      check("clip_drop", a_drop, 0);
      x_in = -27'sd41943040; sample_valid = 1'b1;
      step(); sample_valid = 1'b0; beats = 0;
      repeat (6) begin
         if (a_valid && ack_a) begin bx[0] = a_x; by[0] = a_y; beats++; end
         step();
      end
      check("clip_edge_beats", beats, 1);
      check("clip_edge_x", bx[0], 0);
      check("clip_edge_y", by[0], 240);

      // Backpressure: 10 pushes into 8 slots, two dropped, drain in push order.
      do_reset(); ack_a = 1'b0; y_in = '0;
      for (int i = 0; i < 10; i++) begin
         x_in = 27'(i * 131072); sample_valid = 1'b1;
         step();
         if (i == 5) check("bp_head_mid", a_x, 320);
      end
      sample_valid = 1'b0;
      repeat (3) step();
      check("bp_valid_held", a_valid, 1);
      check("bp_head_stable", a_x, 320);
      check("bp_drop", a_drop, 2);
      ack_a = 1'b1;
      for (int k = 0; k < 8; k++) begin
         check($sformatf("bp_beat%0d_valid", k), a_valid, 1);
         check($sformatf("bp_beat%0d_x", k), a_x, 320 + k);
         step();
      end
      check("bp_empty", a_valid, 0);
      ack_a = 1'b0;

      // Clear: pending beat completes first, then a full 16x8 raster with colour 0.
      do_reset(); ack_b = 1'b0; x_in = '0; y_in = '0; color = 8'h77;
      repeat (4) begin sample_valid = 1'b1; step(); end
      sample_valid = 1'b0; n = 0;
      while (!b_valid && n < 10) begin step(); n++; end
      check("clr_pending_beat", b_valid, 1);
      clear = 1'b1; step(); clear = 1'b0;
      repeat (3) step();
      check("clr_wait_busy", b_busy, 0);
      check("clr_wait_x", b_x, 8);
      check("clr_wait_color", b_color, 8'h77);
      ack_b = 1'b1; sample_valid = 1'b1;
      step();
      check("clr_busy", b_busy, 1);
      errs = 0;
      for (int yy = 0; yy < 8; yy++) begin
         for (int xx = 0; xx < 16; xx++) begin
            if (b_valid !== 1'b1 || b_x !== 10'(xx) || b_y !== 10'(yy) || b_color !== 8'h00) errs++;
            if (xx == 15 && yy == 7) check("clr_busy_last", b_busy, 1);
            step();
         end
      end
      sample_valid = 1'b0;
      check("clr_sweep_errs", errs, 0);
      check("clr_done_busy", b_busy, 0);
      beats = 0;
      repeat (6) begin if (b_valid) beats++; step(); end
      check("clr_no_beats", beats, 0);
      check("clr_drop", b_drop, 0);

      // Async reset in the middle of a sweep.
      do_reset(); ack_b = 1'b0; x_in = '0; y_in = '0;
      repeat (40) begin sample_valid = 1'b1; step(); end
      sample_valid = 1'b0;
      repeat (4) step();
      check("ar_drop_pre", b_drop, 2);
      clear = 1'b1; step(); clear = 1'b0; ack_b = 1'b1;
      repeat (5) step();
      check("ar_busy_pre", b_busy, 1);
      #2 reset = 1'b0;
      #1;
      check("ar_valid", b_valid, 0);
      check("ar_busy", b_busy, 0);
      check("ar_drop", b_drop, 0);
      @(negedge clk); reset = 1'b1; ack_b = 1'b0;
      step();
      repeat (3) begin sample_valid = 1'b1; step(); end
      sample_valid = 1'b0;
      repeat (4) step();
      check("ar_three_samples", b_valid, 0);
      sample_valid = 1'b1; step(); sample_valid = 1'b0;
      step(); step();
      check("ar_fourth_sample", b_valid, 1);
      check("ar_fourth_x", b_x, 8);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
